// File: rtl/spinner_pkg.sv
// Shared types and helpers for the spinner output stage: LED geometry, FSM states
// and the position-to-LED decoder.
package spinner_pkg;

  localparam int NUM_LEDS = 8;
  localparam int POS_W    = 3;

  typedef enum logic [1:0] {
    IDLE,
    SPIN,
    BLINK,
    HOLD
  } state_t;

  function automatic logic [NUM_LEDS-1:0] onehot(input logic [POS_W-1:0] pos);
    logic [NUM_LEDS-1:0] v;
    v      = '0;
    v[pos] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/led_driver_if.sv
// Wheel-to-LED-driver bundle: wheel strobes in, LED drive and landed result out.
interface led_driver_if;
  import spinner_pkg::*;

  logic                tick_i;
  logic [POS_W-1:0]    pos_i;
  logic                running_i;
  logic [NUM_LEDS-1:0] led_o;
  logic [POS_W-1:0]    result_o;
  logic                result_valid_o;

  modport master (
    output tick_i, pos_i, running_i,
    input  led_o, result_o, result_valid_o
  );

  modport slave (
    input  tick_i, pos_i, running_i,
    output led_o, result_o, result_valid_o
  );

endinterface

// File: rtl/led_driver_blink.sv
// Blink sequencer for the landed LED: counts tick strobes into half-periods and
// reports when the last OFF half-period of the last blink has ended.
module led_blink_timer #(
  parameter int BLINK_TICKS = 2000,
  parameter int BLINK_COUNT = 3
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic start_i,
  input  logic abort_i,
  input  logic tick_i,
  output logic phase_on_o,
  output logic done_o
);

  localparam logic [15:0] TICK_LAST  = 16'(BLINK_TICKS - 1);
  localparam logic [3:0]  BLINK_LAST = 4'(BLINK_COUNT - 1);

  logic [15:0] r_tick_cnt;
  logic [3:0]  r_blink_cnt;
  logic        r_phase_on;
  logic        w_half_end;

  assign w_half_end = tick_i && (r_tick_cnt == TICK_LAST);
  assign done_o     = w_half_end && !r_phase_on && (r_blink_cnt == BLINK_LAST);
  assign phase_on_o = r_phase_on;

  // NOTE: sequential state uses non-blocking assignments so every register sees
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i || abort_i || done_o) begin
      r_tick_cnt  <= '0;
      r_blink_cnt <= '0;
      r_phase_on  <= 1'b0;
    end else if (start_i) begin
      r_tick_cnt  <= '0;
      r_blink_cnt <= '0;
      r_phase_on  <= 1'b1;
    end else if (tick_i) begin
      if (w_half_end) begin
        r_tick_cnt <= '0;
        r_phase_on <= !r_phase_on;
        if (!r_phase_on) r_blink_cnt <= r_blink_cnt + 4'd1;
      end else begin
        r_tick_cnt <= r_tick_cnt + 16'd1;
      end
    end
  end

endmodule

// File: rtl/led_driver.sv
// LED output stage behind the wheel: lit position with PWM trail while spinning,
// blink-then-hold on the landed position, and the result handed to the game logic.
module led_driver
  import spinner_pkg::*;
#(
  parameter int BLINK_TICKS = 2000,
  parameter int BLINK_COUNT = 3,
  parameter int PWM_BITS    = 3,
  parameter int TRAIL_DUTY  = 2
) (
  input  logic         clk_i,
  input  logic         rst_i,
  led_driver_if.slave  bus
);

  state_t              r_state, w_state_nxt;
  logic                r_running_q;
  logic [POS_W-1:0]    r_prev_pos, r_cur_pos, r_result;
  logic [PWM_BITS-1:0] r_pwm_cnt;
  logic [NUM_LEDS-1:0] r_led, w_led_nxt;
  logic                r_result_valid;

  logic w_rise, w_fall, w_trail_on;
  logic w_start, w_abort, w_blink_tick, w_phase_on, w_done;

  assign w_rise       = bus.running_i && !r_running_q;
  assign w_fall       = !bus.running_i && r_running_q;
  assign w_trail_on   = int'(r_pwm_cnt) < TRAIL_DUTY;
  assign w_blink_tick = bus.tick_i && (r_state == BLINK);

  led_blink_timer #(
    .BLINK_TICKS (BLINK_TICKS),
    .BLINK_COUNT (BLINK_COUNT)
  ) u_blink (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .start_i    (w_start),
    .abort_i    (w_abort),
    .tick_i     (w_blink_tick),
    .phase_on_o (w_phase_on),
    .done_o     (w_done)
  );

  // NOTE: every output of this block gets a default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_led_nxt   = '0;
    w_start     = 1'b0;
    w_abort     = 1'b0;
    case (r_state)
      IDLE: if (w_rise) w_state_nxt = SPIN;
      SPIN: begin
        w_led_nxt = onehot(bus.pos_i) | (w_trail_on ? onehot(r_prev_pos) : '0);
        if (w_fall) begin
          w_state_nxt = BLINK;
          w_start     = 1'b1;
        end
      end
      BLINK: begin
        w_led_nxt = w_phase_on ? onehot(r_result) : '0;
        if (w_rise) begin
          w_state_nxt = SPIN;
          w_abort     = 1'b1;
        end else if (w_done) begin
          w_state_nxt = HOLD;
        end
      end
      HOLD: begin
        w_led_nxt = onehot(r_result);
        if (w_rise) begin
          w_state_nxt = SPIN;
          w_abort     = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state        <= IDLE;
      r_running_q    <= 1'b0;
      r_prev_pos     <= '0;
      r_cur_pos      <= '0;
      r_pwm_cnt      <= '0;
      r_led          <= '0;
      r_result       <= '0;
      r_result_valid <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_running_q    <= bus.running_i;
      r_pwm_cnt      <= r_pwm_cnt + 1'b1;
      r_led          <= w_led_nxt;
      r_result_valid <= (w_state_nxt == HOLD);
      // Entering SPIN collapses the trail onto the current position.
      if (r_state != SPIN && w_state_nxt == SPIN) begin
        r_prev_pos <= bus.pos_i;
        r_cur_pos  <= bus.pos_i;
      end else if (r_state == SPIN && bus.pos_i != r_cur_pos) begin
        r_prev_pos <= r_cur_pos;
        r_cur_pos  <= bus.pos_i;
      end
      if (w_start) r_result <= bus.pos_i;
    end
  end

  assign bus.led_o          = r_led;
  assign bus.result_o       = r_result;
  assign bus.result_valid_o = r_result_valid;

endmodule
